// File: rtl/gb_cpu_prefetch_decoder.sv
// Byte queue plus head-opcode classifier that hands the decoder one whole
// instruction per handshake, with ISR injection at boundaries and redirect flush.
module gb_cpu_prefetch_decoder #(
  parameter int DEPTH  = 4,
  parameter bit ISR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [7:0]  fetch_byte,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic        irq_req,
  output logic        irq_ack,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic        instr_cb,
  output logic        instr_isr,
  output logic        instr_illegal,
  output logic [15:0] instr_imm,
  output logic [1:0]  instr_len
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW:0]   DEPTH_P = (PW + 1)'(DEPTH);

  if (DEPTH < 3 || DEPTH > 16) begin : g_depth_check
    $error("gb_cpu_prefetch_decoder: DEPTH must be in 3..16");
  end

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_eff;
  logic          push, load, take_isr, take_q, head_cb;
  logic [1:0]    need, pop_n;
  logic [7:0]    b0, b1, b2;
  logic [7:0]    nxt_opcode;
  logic [15:0]   nxt_imm;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW + 1)'(k);
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PW-1:0];
  endfunction

  function automatic logic [1:0] need_len(input logic [7:0] h);
    case (h)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
      8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA: return 2'd3;
      8'hCB, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hE0, 8'hE8, 8'hF0, 8'hF8:                              return 2'd2;
      default: return (h[2:0] == 3'b110 && (h[7:6] == 2'b00 || h[7:6] == 2'b11))
                      ? 2'd2 : 2'd1;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [7:0] op);
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Bytes not yet queued come straight from the fetch bus, so an instruction
  // completes in the same cycle its last byte arrives.
  always_comb begin
    fetch_ready = !reset && (count < DEPTH_C);
    push        = fetch_valid && fetch_ready && !flush;
    count_eff   = count + CW'(push);
    b0          = (count != '0)         ? mem[rd_ptr]             : fetch_byte;
    b1          = (count >= CW'(2))     ? mem[ptr_add(rd_ptr, 2'd1)] : fetch_byte;
    b2          = (count >= CW'(3))     ? mem[ptr_add(rd_ptr, 2'd2)] : fetch_byte;
    need        = need_len(b0);
    head_cb     = (b0 == 8'hCB);
    load        = !instr_valid || instr_ready;
    take_isr    = ISR_EN && irq_req && load && !flush && !reset;
    take_q      = load && !take_isr && (count_eff >= CW'(need));
    pop_n       = take_q ? need : 2'd0;
    irq_ack     = take_isr;
    nxt_opcode  = 8'h00;
    nxt_imm     = 16'h0000;
    if (take_q) begin
      nxt_opcode = head_cb ? b1 : b0;
      if (!head_cb && need == 2'd3) nxt_imm = {b2, b1};
      else if (!head_cb && need == 2'd2) nxt_imm = {8'h00, b1};
    end
    instr_illegal = !instr_cb && !instr_isr && is_illegal(instr_opcode);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fetch_byte;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      instr_valid  <= 1'b0;
      instr_opcode <= 8'h00;
      instr_cb     <= 1'b0;
      instr_isr    <= 1'b0;
      instr_imm    <= 16'h0000;
      instr_len    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_add(wr_ptr, 2'd1);
      rd_ptr <= ptr_add(rd_ptr, pop_n);
      count  <= count_eff - CW'(pop_n);
      if (load) begin
        instr_valid  <= take_isr || take_q;
        instr_isr    <= take_isr;
        instr_cb     <= take_q && head_cb;
        instr_opcode <= nxt_opcode;
        instr_imm    <= nxt_imm;
        instr_len    <= take_q ? need : 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_gb_cpu_prefetch_decoder.sv
// Directed vector bench for gb_cpu_prefetch_decoder (DEPTH=4), with an
// ISR_EN=0 instance sharing the stimulus to confirm injection is disabled.
module tb_gb_cpu_prefetch_decoder;

  logic clk, reset, fetch_valid, flush, irq_req, instr_ready;
  logic [7:0] fetch_byte;
  logic fetch_ready, irq_ack, instr_valid, instr_cb, instr_isr, instr_illegal;
  logic [7:0] instr_opcode;
  logic [15:0] instr_imm;
  logic [1:0] instr_len;
  logic fr0, ack0, v0, cb0, isr0, ill0;
  logic [7:0] op0;
  logic [15:0] imm0;
  logic [1:0] len0;

  int n_pass = 0;
  int n_total = 0;

  gb_cpu_prefetch_decoder #(.DEPTH(4), .ISR_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_byte(fetch_byte),
    .fetch_ready(fetch_ready), .flush(flush), .irq_req(irq_req), .irq_ack(irq_ack),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_cb(instr_cb), .instr_isr(instr_isr), .instr_illegal(instr_illegal),
    .instr_imm(instr_imm), .instr_len(instr_len)
  );

  gb_cpu_prefetch_decoder #(.DEPTH(4), .ISR_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_byte(fetch_byte),
    .fetch_ready(fr0), .flush(flush), .irq_req(irq_req), .irq_ack(ack0),
    .instr_valid(v0), .instr_ready(instr_ready), .instr_opcode(op0),
    .instr_cb(cb0), .instr_isr(isr0), .instr_illegal(ill0),
    .instr_imm(imm0), .instr_len(len0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [7:0]  fb;
    logic        rdy;
    logic        irq;
    logic        fl;
    logic [1:0]  pre;   // {fetch_ready, irq_ack} before the edge
    logic [29:0] post;  // {valid, cb, isr, illegal, len, opcode, imm} after the edge
  } vec_t;

  vec_t tv[$];

  function automatic logic [29:0] o(input logic [7:0] op, input logic [1:0] len,
                                    input logic [15:0] imm, input logic cb = 1'b0,
                                    input logic isr = 1'b0, input logic ill = 1'b0);
    return {1'b1, cb, isr, ill, len, op, imm};
  endfunction

  function automatic vec_t mk(input logic fv, input logic [7:0] fb, input logic rdy,
                              input logic irq, input logic fl, input logic fr,
                              input logic ack, input logic [29:0] post);
    vec_t v;
    v.fv = fv; v.fb = fb; v.rdy = rdy; v.irq = irq; v.fl = fl;
    v.pre = {fr, ack}; v.post = post;
    return v;
  endfunction

  function automatic logic [29:0] bundle();
    return {instr_valid, instr_cb, instr_isr, instr_illegal, instr_len, instr_opcode, instr_imm};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fetch_valid = 1'b0; fetch_byte = 8'h00; flush = 1'b0; irq_req = 1'b0;
    instr_ready = 1'b0; reset = 1'b1;

    // 2-byte, 3-byte, 1-byte, CB-prefixed
    tv.push_back(mk(1, 8'h3E, 1, 0, 0, 1, 0, '0));
    tv.push_back(mk(1, 8'h42, 1, 0, 0, 1, 0, o(8'h3E, 2, 16'h0042)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, '0));
    tv.push_back(mk(1, 8'hCD, 1, 0, 0, 1, 0, '0));
    tv.push_back(mk(1, 8'h34, 1, 0, 0, 1, 0, '0));
    tv.push_back(mk(1, 8'h12, 1, 0, 0, 1, 0, o(8'hCD, 3, 16'h1234)));
    tv.push_back(mk(1, 8'h00, 1, 0, 0, 1, 0, o(8'h00, 1, 16'h0000)));
    tv.push_back(mk(1, 8'hCB, 1, 0, 0, 1, 0, '0));
    tv.push_back(mk(1, 8'h37, 1, 0, 0, 1, 0, o(8'h37, 2, 16'h0000, 1)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, '0));
    // fill to full with the consumer stalled, then drain with wrap
    tv.push_back(mk(1, 8'h40, 0, 0, 0, 1, 0, o(8'h40, 1, 0)));
    tv.push_back(mk(1, 8'h41, 0, 0, 0, 1, 0, o(8'h40, 1, 0)));
    tv.push_back(mk(1, 8'h42, 0, 0, 0, 1, 0, o(8'h40, 1, 0)));
    tv.push_back(mk(1, 8'h43, 0, 0, 0, 1, 0, o(8'h40, 1, 0)));
    tv.push_back(mk(1, 8'h44, 0, 0, 0, 1, 0, o(8'h40, 1, 0)));
    tv.push_back(mk(1, 8'h45, 0, 0, 0, 0, 0, o(8'h40, 1, 0)));
    tv.push_back(mk(1, 8'h45, 1, 0, 0, 0, 0, o(8'h41, 1, 0)));
    tv.push_back(mk(1, 8'h45, 1, 0, 0, 1, 0, o(8'h42, 1, 0)));
    tv.push_back(mk(1, 8'h46, 1, 0, 0, 1, 0, o(8'h43, 1, 0)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, o(8'h44, 1, 0)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, o(8'h45, 1, 0)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, o(8'h46, 1, 0)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, '0));
    // interrupt injected ahead of a partial FA instruction
    tv.push_back(mk(1, 8'hFA, 1, 0, 0, 1, 0, '0));
    tv.push_back(mk(1, 8'h00, 1, 0, 0, 1, 0, '0));
    tv.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, o(8'h00, 0, 16'h0000, 0, 1)));
    tv.push_back(mk(1, 8'hC0, 1, 0, 0, 1, 0, o(8'hFA, 3, 16'hC000)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, '0));
    // illegal opcode, and the same byte behind CB is legal
    tv.push_back(mk(1, 8'hD3, 1, 0, 0, 1, 0, o(8'hD3, 1, 16'h0000, 0, 0, 1)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, '0));
    tv.push_back(mk(1, 8'hCB, 1, 0, 0, 1, 0, '0));
    tv.push_back(mk(1, 8'hD3, 1, 0, 0, 1, 0, o(8'hD3, 2, 16'h0000, 1)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, '0));
    // flush over a held output and a partial instruction, with a push
    tv.push_back(mk(1, 8'h40, 0, 0, 0, 1, 0, o(8'h40, 1, 0)));
    tv.push_back(mk(1, 8'h01, 0, 0, 0, 1, 0, o(8'h40, 1, 0)));
    tv.push_back(mk(1, 8'h34, 0, 0, 0, 1, 0, o(8'h40, 1, 0)));
    tv.push_back(mk(1, 8'h12, 0, 0, 1, 1, 0, '0));
    tv.push_back(mk(1, 8'h00, 1, 0, 0, 1, 0, o(8'h00, 1, 0)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, '0));
    // flush suppresses the ack; injection follows once flush drops
    tv.push_back(mk(0, 8'h00, 1, 1, 1, 1, 0, '0));
    tv.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, o(8'h00, 0, 16'h0000, 0, 1)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, '0));

    step();
    step();
    chk("rst_fready_low", fetch_ready, 1'b0);
    chk("rst_outputs", {bundle(), irq_ack}, '0);
    reset = 1'b0;
    #1;
    chk("post_rst_fready", fetch_ready, 1'b1);

    for (int i = 0; i < tv.size(); i++) begin
      fetch_valid = tv[i].fv; fetch_byte = tv[i].fb; instr_ready = tv[i].rdy;
      irq_req = tv[i].irq; flush = tv[i].fl;
      #1;
      chk($sformatf("v%0d_ready_ack", i), {fetch_ready, irq_ack}, tv[i].pre);
      if (tv[i].irq) chk($sformatf("v%0d_noisr_ack", i), ack0, 1'b0);
      step();
      chk($sformatf("v%0d_out", i), bundle(), tv[i].post);
      if (tv[i].irq) chk($sformatf("v%0d_noisr_out", i), isr0, 1'b0);
    end

    // reset in the middle of a 3-byte instruction, with a push pending
    fetch_valid = 1'b1; fetch_byte = 8'h01; instr_ready = 1'b0; irq_req = 1'b0; flush = 1'b0;
    step();
    fetch_byte = 8'h34;
    step();
    reset = 1'b1; fetch_byte = 8'h12;
    #1;
    chk("midrst_fready", fetch_ready, 1'b0);
    step();
    reset = 1'b0; fetch_valid = 1'b0;
    #1;
    chk("midrst_out", bundle(), '0);
    chk("midrst_fready_after", fetch_ready, 1'b1);
    fetch_valid = 1'b1; fetch_byte = 8'h00; instr_ready = 1'b1;
    step();
    chk("midrst_queue_empty", bundle(), o(8'h00, 1, 0));
    fetch_valid = 1'b0;
    step();
    chk("midrst_drain", bundle(), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gb_cpu_prefetch_decoder.md
Name: gb_cpu_prefetch_decoder

Overview:
Parametrised instruction assembler between the memory-fetch path and the micro-op decoder. Buffers fetched bytes in a DEPTH-entry queue and classifies the head opcode: length, CB prefix, immediate bytes, legality. It then emits one complete instruction per handshake (opcode, CB flag, immediate), so the decoder never waits mid-instruction. Also arbitrates ISR injection at instruction boundaries and supports a flush on control-flow redirect.

Parameters:
DEPTH, 4, byte-queue entries; legal range 3..16; elaboration error outside range.
ISR_EN, 1, 1 = interrupt injection enabled; 0 = irq_req ignored, irq_ack tied 0.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
fetch_valid  input  1  fetch_byte valid
fetch_byte  input  8  fetched code byte, in program order
fetch_ready  output  1  queue can accept a byte this cycle
flush  input  1  discard all queued/held bytes (jump/call/ret/rst taken)
irq_req  input  1  pending enabled interrupt; held high until irq_ack
irq_ack  output  1  one-cycle pulse when ISR entry loaded into output
instr_valid  output  1  output register holds a complete instruction
instr_ready  input  1  consumer accepts instruction
instr_opcode  output  8  opcode (byte after 0xCB when instr_cb=1)
instr_cb  output  1  CB-prefixed instruction
instr_isr  output  1  entry is injected ISR, not fetched code
instr_illegal  output  1  opcode in {D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD}
instr_imm  output  16  immediate; imm8 in [7:0] with [15:8]=0; imm16 little-endian (first byte low)
instr_len  output  2  bytes consumed: 0 (ISR), 1, 2, 3

Behaviour:
- Reset: queue empty; all outputs 0, except fetch_ready=1 in the cycle after reset deasserts. While reset is high, fetch_ready=0.
- Queue: fetch_ready = (count < DEPTH). A push occurs on fetch_valid && fetch_ready. count width is clog2(DEPTH+1). Write and read pointers wrap modulo DEPTH. A push and a pop in the same cycle are both legal, including when full: fetch_ready is computed before the pop, so no push occurs in that cycle.
- Required bytes N for the head byte h0:
  - 3 if h0 in {01,11,21,31,08,C2,C3,C4,CA,CC,CD,D2,D4,DA,DC,EA,FA}.
  - 2 if h0 = CB.
  - 2 if h0 matches 00xxx110 or 11xxx110.
  - 2 if h0 in {18,20,28,30,38,E0,E8,F0,F8}.
  - 1 otherwise, including 10 (stop) and illegal opcodes.
- Load condition: output register empty, or instr_valid && instr_ready in this cycle.
- Load priority when the load condition holds:
  1. If ISR_EN && irq_req: load ISR entry (instr_isr=1, opcode=00, cb=0, imm=0, len=0), pulse irq_ack, pop nothing.
  2. Else if count >= N: load from queue and pop N bytes.
    - CB: opcode = byte1, cb=1, len=2, imm=0.
    - Others: opcode = h0, imm from bytes 1..2, len=N.
  3. Else: instr_valid deasserts (after a consume) or stays 0.
- Output registers stay stable while instr_valid && !instr_ready.
- Latency: with the output empty, the instruction is valid on the cycle after its last byte is pushed.
- Back-to-back 1-byte instructions sustain one per cycle when fetch keeps pace.
- irq_req is sampled only at the load point; an in-progress partial instruction stays queued untouched.
- flush (priority over everything except reset): next cycle count=0 and instr_valid=0. A push in the same cycle is discarded; irq_ack is not generated that cycle.
- instr_illegal is decoded from instr_opcode with instr_cb=0 and instr_isr=0; otherwise 0.

Test Plan:
- Push 3E,42 with instr_ready=1 -> one cycle after 42 is pushed: valid, opcode 3E, imm 0042, len 2, then valid drops.
- Push CD,34,12 then 00 -> CD with imm 1234, len 3, followed next cycle by opcode 00, len 1. Push CB,37 -> opcode 37, cb=1, len 2.
- DEPTH=4, instr_ready=0, push 00 x6 -> 1 in output + 4 queued, fetch_ready=0. Pop/push in the same full cycle: no overflow; pointers wrap and order is preserved.
- Push FA,00 (incomplete), raise irq_req -> ISR entry emitted (isr=1, len 0), irq_ack 1 cycle. Push C0 -> FA with imm C000 emitted next.
- Hold instr_valid with instr_ready=0, then assert flush with a simultaneous push -> next cycle instr_valid=0, count=0. Reset asserted mid-3-byte instruction gives the same result.
- Push D3 -> instr_illegal=1, len 1. Set ISR_EN=0 with irq_req=1 -> no injection, irq_ack stays 0.
